// File: rtl/spi_master_multi.sv
// SPI master with configurable word width, runtime CPOL/CPHA, multiple chip selects with
// burst CS hold, and an optional chip-ready wait (MISO low after CS) with timeout abort.
module spi_master_multi #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned NUM_CS   = 2,
  parameter int unsigned CS_W     = 1,
  parameter int unsigned READY_TO = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              hold_cs,
  input  logic              wait_rdy,
  input  logic              miso,
  output logic              mosi,
  output logic              sck,
  output logic [NUM_CS-1:0] cs_n,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              rdy_timeout
);

  localparam int unsigned DivW  = $clog2(CLK_DIV + 1);
  localparam int unsigned EdgeW = $clog2(2 * DATA_W + 1);
  localparam int unsigned TmrW  = $clog2(READY_TO + 1);

  typedef enum logic [2:0] {StIdle, StCsGap, StCsSetup, StReadyWait, StShift, StCsHold} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   cnt_q, cnt_d;
  logic [EdgeW-1:0]  edge_q, edge_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, data_out_q, data_out_d;
  logic [CS_W-1:0]   sel_q, sel_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d, hold_q, hold_d, wait_q, wait_d;
  logic cs_held_q, cs_held_d, miso_q, miso_d, sck_q, sck_d, mosi_q, mosi_d;
  logic busy_q, busy_d, done_q, done_d, rdy_to_q, rdy_to_d;
  logic div_tick, lead;

  function automatic logic [NUM_CS-1:0] cs_low(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] m;
    m = '1;
    for (int i = 0; i < int'(NUM_CS); i++) begin
      if (int'(sel) == i) m[i] = 1'b0;
    end
    return m;
  endfunction

  assign div_tick = (cnt_q == DivW'(CLK_DIV - 1));
  assign lead     = ~edge_q[0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    tmr_d      = tmr_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    sel_d      = sel_q;
    cs_n_d     = cs_n_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    hold_d     = hold_q;
    wait_d     = wait_q;
    cs_held_d  = cs_held_q;
    miso_d     = miso;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rdy_to_d   = rdy_to_q;
    case (state_q)
      StIdle: begin
        sck_d  = cpol_q;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          sel_d     = cs_sel;
          cpol_d    = cpol;
          cpha_d    = cpha;
          hold_d    = hold_cs;
          wait_d    = wait_rdy;
          sck_d     = cpol;
          // cpha=0 presents the MSB before the first edge; cpha=1 shifts it out on the first edge
          tx_d      = cpha ? data_in : (data_in << 1);
          mosi_d    = cpha ? 1'b0 : data_in[DATA_W-1];
          busy_d    = 1'b1;
          rdy_to_d  = 1'b0;
          cs_held_d = 1'b0;
          cnt_d     = '0;
          edge_d    = '0;
          if (cs_held_q && (cs_sel != sel_q)) begin
            cs_n_d  = '1;
            state_d = StCsGap;
          end else begin
            cs_n_d  = cs_low(cs_sel);
            state_d = StCsSetup;
          end
        end
      end
      StCsGap: begin
        cnt_d = cnt_q + 1'b1;
        if (div_tick) begin
          cnt_d   = '0;
          cs_n_d  = cs_low(sel_q);
          state_d = StCsSetup;
        end
      end
      StCsSetup: begin
        cnt_d = cnt_q + 1'b1;
        if (div_tick) begin
          cnt_d   = '0;
          tmr_d   = '0;
          state_d = wait_q ? StReadyWait : StShift;
        end
      end
      StReadyWait: begin
        if (!miso_q) begin
          cnt_d   = '0;
          state_d = StShift;
        end else if (tmr_q == TmrW'(READY_TO - 1)) begin
          cs_n_d    = '1;
          cs_held_d = 1'b0;
          rdy_to_d  = 1'b1;
          done_d    = 1'b1;
          mosi_d    = 1'b0;
          state_d   = StIdle;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StShift: begin
        cnt_d = cnt_q + 1'b1;
        if (div_tick) begin
          cnt_d  = '0;
          sck_d  = ~sck_q;
          edge_d = edge_q + 1'b1;
          if (lead ^ cpha_q) begin
            rx_d = {rx_q[DATA_W-2:0], miso};
          end else begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = tx_q << 1;
          end
          if (edge_q == EdgeW'(2 * DATA_W - 1)) state_d = StCsHold;
        end
      end
      StCsHold: begin
        cnt_d = cnt_q + 1'b1;
        if (div_tick) begin
          cnt_d      = '0;
          if (!hold_q) cs_n_d = '1;
          cs_held_d  = hold_q;
          data_out_d = rx_q;
          done_d     = 1'b1;
          mosi_d     = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      edge_q     <= '0;
      tmr_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      sel_q      <= '0;
      cs_n_q     <= '1;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      hold_q     <= 1'b0;
      wait_q     <= 1'b0;
      cs_held_q  <= 1'b0;
      miso_q     <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdy_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      tmr_q      <= tmr_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      sel_q      <= sel_d;
      cs_n_q     <= cs_n_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      hold_q     <= hold_d;
      wait_q     <= wait_d;
      cs_held_q  <= cs_held_d;
      miso_q     <= miso_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdy_to_q   <= rdy_to_d;
    end
  end

  assign mosi        = mosi_q;
  assign sck         = sck_q;
  assign cs_n        = cs_n_q;
  assign data_out    = data_out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rdy_timeout = rdy_to_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: a behavioural SPI slave plus a table of single transfers and
// hand-written burst, ready-timeout and mid-transfer reset sequences.
module tb_spi_master_multi;
  localparam int DW  = 8;
  localparam int CD  = 2;
  localparam int RTO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, cpol = 1'b0, cpha = 1'b0, hold_cs = 1'b0, wait_rdy = 1'b0;
  logic [7:0] data_in = '0;
  logic [1:0] cs_sel = '0;
  logic       miso, mosi, sck, busy, done, rdy_timeout;
  logic [1:0] cs_n;
  logic [7:0] data_out;

  spi_master_multi #(
    .DATA_W(DW), .CLK_DIV(CD), .NUM_CS(2), .CS_W(2), .READY_TO(RTO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .cs_sel(cs_sel), .cpol(cpol),
    .cpha(cpha), .hold_cs(hold_cs), .wait_rdy(wait_rdy), .miso(miso), .mosi(mosi), .sck(sck),
    .cs_n(cs_n), .data_out(data_out), .busy(busy), .done(done), .rdy_timeout(rdy_timeout)
  );

  always #5 clk = ~clk;

  // Slave device model: loads a word when slv_load toggles, then follows SCK per its mode.
  logic       m_cpol = 1'b0, m_cpha = 1'b0, slv_load = 1'b0, force_hi = 1'b0;
  logic [7:0] slv_word = '0;
  logic       load_seen = 1'b0, sck_seen = 1'b0, lead_next = 1'b1, sl_miso = 1'b0;
  logic [7:0] sl_tx = '0, sl_rx = '0;
  int         tog_cnt = 0;

  assign miso = force_hi ? 1'b1 : sl_miso;

  always @(sck or slv_load) begin
    if (slv_load !== load_seen) begin
      load_seen = slv_load;
      lead_next = 1'b1;
      sl_rx = '0;
      if (m_cpha) begin
        sl_tx = slv_word;
        sl_miso = 1'b0;
      end else begin
        sl_miso = slv_word[7];
        sl_tx = {slv_word[6:0], 1'b0};
      end
    end else if (sck !== sck_seen) begin
      sck_seen = sck;
      tog_cnt++;
      if (lead_next && sck === ~m_cpol) begin
        lead_next = 1'b0;
        if (m_cpha) begin sl_miso = sl_tx[7]; sl_tx = {sl_tx[6:0], 1'b0}; end
        else sl_rx = {sl_rx[6:0], mosi};
      end else if (!lead_next && sck === m_cpol) begin
        lead_next = 1'b1;
        if (m_cpha) sl_rx = {sl_rx[6:0], mosi};
        else begin sl_miso = sl_tx[7]; sl_tx = {sl_tx[6:0], 1'b0}; end
      end
    end
  end

  int total = 0, bad = 0;
  logic prev_cpol = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       cpol, cpha;
    logic [1:0] sel;
    logic [7:0] din, sw;
    logic       hold, wrdy;
    int         lat;
    logic [1:0] cs_first, cs_mid, cs_end;
  } vec_t;

  vec_t vecs[7];

  task automatic load_slave(input logic pol, input logic pha, input logic [7:0] w);
    m_cpol = pol;
    m_cpha = pha;
    slv_word = w;
    slv_load = ~slv_load;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n, tog0;
    logic seen;
    @(negedge clk);
    load_slave(v.cpol, v.cpha, v.sw);
    cpol = v.cpol; cpha = v.cpha; cs_sel = v.sel; data_in = v.din;
    hold_cs = v.hold; wait_rdy = v.wrdy; start = 1'b1;
    tog0 = tog_cnt;
    n = 0;
    seen = 1'b0;
    while (n < 200 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({tag, " busy_first"}, busy, 1);
        chk({tag, " cs_first"}, cs_n, v.cs_first);
        chk({tag, " rdy_to_clear"}, rdy_timeout, 0);
        start = 1'b0;
      end
      if (n == 20) chk({tag, " cs_mid"}, cs_n, v.cs_mid);
      if (done) seen = 1'b1;
    end
    chk({tag, " latency"}, n, v.lat);
    chk({tag, " data_out"}, data_out, v.sw);
    chk({tag, " slave_rx"}, sl_rx, v.din);
    chk({tag, " cs_end"}, cs_n, v.cs_end);
    chk({tag, " sck_idle"}, sck, v.cpol);
    chk({tag, " sck_toggles"}, tog_cnt - tog0, 16 + ((v.cpol != prev_cpol) ? 1 : 0));
    prev_cpol = v.cpol;
    @(negedge clk);
    chk({tag, " done_pulse"}, done, 0);
    chk({tag, " busy_end"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, csbad, dcnt, nd, tog0;
    vecs[0] = '{1'b0, 1'b0, 2'd1, 8'hA5, 8'h3C, 1'b0, 1'b0, 37, 2'b01, 2'b01, 2'b11};
    vecs[1] = '{1'b1, 1'b1, 2'd0, 8'h81, 8'h7E, 1'b0, 1'b0, 37, 2'b10, 2'b10, 2'b11};
    vecs[2] = '{1'b0, 1'b1, 2'd1, 8'hC3, 8'h5A, 1'b0, 1'b0, 37, 2'b01, 2'b01, 2'b11};
    vecs[3] = '{1'b1, 1'b0, 2'd0, 8'h0F, 8'hF0, 1'b1, 1'b0, 37, 2'b10, 2'b10, 2'b10};
    vecs[4] = '{1'b0, 1'b0, 2'd1, 8'h96, 8'h69, 1'b0, 1'b0, 39, 2'b11, 2'b01, 2'b11};
    vecs[5] = '{1'b0, 1'b0, 2'd2, 8'h55, 8'hAA, 1'b0, 1'b0, 37, 2'b11, 2'b11, 2'b11};
    vecs[6] = '{1'b0, 1'b0, 2'd0, 8'hE7, 8'h12, 1'b0, 1'b1, 38, 2'b10, 2'b10, 2'b11};

    repeat (3) @(negedge clk);
    chk("rst cs_n", cs_n, 2'b11);
    chk("rst sck", sck, 0);
    chk("rst mosi", mosi, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst data_out", data_out, 0);
    chk("rst rdy_timeout", rdy_timeout, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Burst: two words on one CS with start held high throughout the first word
    @(negedge clk);
    load_slave(1'b0, 1'b0, 8'h5C);
    cpol = 1'b0; cpha = 1'b0; cs_sel = 2'd1; hold_cs = 1'b1; wait_rdy = 1'b0;
    data_in = 8'h11; start = 1'b1;
    n = 0;
    csbad = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) begin data_in = 8'h22; hold_cs = 1'b0; end
      if (cs_n !== 2'b01) csbad++;
      if (done) break;
    end
    chk("burst1 latency", n, 37);
    chk("burst1 data_out", data_out, 8'h5C);
    chk("burst1 slave_rx", sl_rx, 8'h11);
    chk("burst1 busy", busy, 1);
    load_slave(1'b0, 1'b0, 8'hC5);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("burst2 busy_kept", busy, 1);
        start = 1'b0;
      end
      if (done) break;
      if (cs_n !== 2'b01) csbad++;
    end
    chk("burst2 latency", n, 37);
    chk("burst2 data_out", data_out, 8'hC5);
    chk("burst2 slave_rx", sl_rx, 8'h22);
    chk("burst cs_held_cycles", csbad, 0);
    chk("burst2 cs_end", cs_n, 2'b11);
    @(negedge clk);
    chk("burst busy_end", busy, 0);

    // Ready wait with MISO stuck high: abort after READY_TO cycles
    @(negedge clk);
    force_hi = 1'b1;
    load_slave(1'b0, 1'b0, 8'h00);
    cpol = 1'b0; cpha = 1'b0; cs_sel = 2'd0; hold_cs = 1'b1; wait_rdy = 1'b1;
    data_in = 8'h5A; start = 1'b1;
    tog0 = tog_cnt;
    dcnt = 0;
    nd = 0;
    for (int i = 1; i <= RTO + 10; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done) begin dcnt++; nd = i; end
    end
    chk("timeout done_count", dcnt, 1);
    chk("timeout done_cycle", nd, 1 + CD + RTO);
    chk("timeout sck_toggles", tog_cnt - tog0, 0);
    chk("timeout flag", rdy_timeout, 1);
    chk("timeout cs_n", cs_n, 2'b11);
    chk("timeout data_out", data_out, 8'hC5);
    chk("timeout busy", busy, 0);
    force_hi = 1'b0;
    prev_cpol = 1'b0;
    run_vec(vecs[0], "after_timeout");

    // Asynchronous reset in the middle of the shift phase
    @(negedge clk);
    load_slave(1'b0, 1'b0, 8'h3C);
    cpol = 1'b0; cpha = 1'b0; cs_sel = 2'd1; hold_cs = 1'b0; wait_rdy = 1'b0;
    data_in = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    chk("pre_rst busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst cs_n", cs_n, 2'b11);
    chk("midrst sck", sck, 0);
    chk("midrst busy", busy, 0);
    chk("midrst data_out", data_out, 0);
    chk("midrst done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    prev_cpol = 1'b0;
    run_vec(vecs[0], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
